// File: rtl/bram_pkg.sv
// Shared constants and helpers for the true dual-port byte-enable BRAM.
package bram_pkg;

  localparam int unsigned WM_READ_FIRST  = 0;
  localparam int unsigned WM_WRITE_FIRST = 1;
  localparam int unsigned WM_NO_CHANGE   = 2;

  // Number of byte lanes in a word of the given bit width.
  function automatic int unsigned bytes_of(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/bram_port_pipe.sv
// Per-port result pipeline: write-mode merge, NO_CHANGE hold, latency stages, reset clearing.
module bram_port_pipe
  import bram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned WRITE_MODE   = WM_READ_FIRST,
  localparam int unsigned BYTES       = bytes_of(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [BYTES-1:0]      we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] ram_rd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid
);

  logic                  acc_c;
  logic                  s1_v_q, s1_v_d;
  logic                  s1_upd_q, s1_upd_d;
  logic [BYTES-1:0]      s1_we_q, s1_we_d;
  logic [DATA_WIDTH-1:0] s1_din_q, s1_din_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] merged_c;
  logic [DATA_WIDTH-1:0] word1_c;

  assign acc_c = en & ~rst;

  // Capture request attributes alongside the array read; NO_CHANGE writes do not refresh dout.
  always_comb begin
    s1_v_d   = acc_c;
    s1_upd_d = acc_c & ~((WRITE_MODE == WM_NO_CHANGE) && (|we));
    s1_we_d  = s1_we_q;
    s1_din_d = s1_din_q;
    if (acc_c) begin
      s1_we_d  = we;
      s1_din_d = din;
    end
  end

  // Word seen after the first stage: merged write data for WRITE_FIRST, else the old word; held otherwise.
  always_comb begin
    merged_c = ram_rd;
    if (WRITE_MODE == WM_WRITE_FIRST) begin
      for (int i = 0; i < int'(BYTES); i++) begin
        if (s1_we_q[i]) merged_c[i*8 +: 8] = s1_din_q[i*8 +: 8];
      end
    end
    word1_c = s1_upd_q ? merged_c : out_q;
    out_d   = word1_c;
  end

  // First stage and last-presented-word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_upd_q <= 1'b0;
      s1_we_q  <= '0;
      s1_din_q <= '0;
      out_q    <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_upd_q <= s1_upd_d;
      s1_we_q  <= s1_we_d;
      s1_din_q <= s1_din_d;
      out_q    <= out_d;
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign dout  = rst ? '0 : word1_c;
    assign valid = s1_v_q & ~rst;
  end else begin : g_lat2
    logic v2_q, v2_d;

    // Second-stage valid follows the first stage by one edge.
    always_comb begin
      v2_d = s1_v_q;
    end

    // Second-stage valid register.
    always_ff @(posedge clk) begin
      if (rst) v2_q <= 1'b0;
      else     v2_q <= v2_d;
    end

    assign dout  = rst ? '0 : out_q;
    assign valid = v2_q & ~rst;
  end

endmodule

// File: rtl/bram_tdp_be.sv
// True dual-port byte-enable BRAM with selectable latency, write mode and fixed collision rules.
module bram_tdp_be
  import bram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned WRITE_MODE   = WM_READ_FIRST,
  localparam int unsigned BYTES       = bytes_of(DATA_WIDTH),
  localparam int unsigned DEPTH       = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_a,
  input  logic [BYTES-1:0]      we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  valid_a,
  input  logic                  en_b,
  input  logic [BYTES-1:0]      we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  valid_b
);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("bram_tdp_be: READ_LATENCY must be 1 or 2");
  end
  if (WRITE_MODE > 2) begin : g_bad_write_mode
    $error("bram_tdp_be: WRITE_MODE must be 0, 1 or 2");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("bram_tdp_be: DATA_WIDTH must be a multiple of 8");
  end

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  acc_a_c, acc_b_c;
  logic [DATA_WIDTH-1:0] ram_a_q, ram_b_q;

  assign acc_a_c = en_a & ~rst;
  assign acc_b_c = en_b & ~rst;

  // Byte writes; port A is applied last so it owns any byte both ports write.
  always_ff @(posedge clk) begin
    if (acc_b_c) begin
      for (int i = 0; i < int'(BYTES); i++) begin
        if (we_b[i]) mem[addr_b][i*8 +: 8] <= din_b[i*8 +: 8];
      end
    end
    if (acc_a_c) begin
      for (int i = 0; i < int'(BYTES); i++) begin
        if (we_a[i]) mem[addr_a][i*8 +: 8] <= din_a[i*8 +: 8];
      end
    end
  end

  // Registered array reads always see the pre-write word, which covers cross-port collisions.
  always_ff @(posedge clk) begin
    if (acc_a_c) ram_a_q <= mem[addr_a];
    if (acc_b_c) ram_b_q <= mem[addr_b];
  end

  bram_port_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY),
    .WRITE_MODE  (WRITE_MODE)
  ) u_pipe_a (
    .clk   (clk),
    .rst   (rst),
    .en    (en_a),
    .we    (we_a),
    .din   (din_a),
    .ram_rd(ram_a_q),
    .dout  (dout_a),
    .valid (valid_a)
  );

  bram_port_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY),
    .WRITE_MODE  (WRITE_MODE)
  ) u_pipe_b (
    .clk   (clk),
    .rst   (rst),
    .en    (en_b),
    .we    (we_b),
    .din   (din_b),
    .ram_rd(ram_b_q),
    .dout  (dout_b),
    .valid (valid_b)
  );

endmodule
